ram_multiport: RTL and testbench

RAM_MULTIPORT -- requirements
Module: ram_multiport

---
 rtl/mmu_ram_pkg.sv | 19 +
 rtl/ram_clear_ctrl.sv | 65 ++++++
 rtl/ram_multiport.sv | 111 +++++++++++
 tb/tb_ram_multiport.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmu_ram_pkg.sv
// Shared types and constants for the multi-port RAM and its clear controller.
// Latency: none (declarations only).
// Backpressure: none.
package mmu_ram_pkg;

   // Clear controller states: IDLE accepts traffic, CLEAR sweeps zeros through the array.
   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } clr_state_e;

   localparam int COLL_CNT_W = 16;

   // Saturating increment for the collision counter.
   function automatic logic [COLL_CNT_W-1:0] coll_sat_inc(input logic [COLL_CNT_W-1:0] cnt);
      return (cnt == {COLL_CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
   endfunction

endpackage

// File: rtl/ram_clear_ctrl.sv
// Clear sequencer: writes zero to one address per cycle, 0 upward, then reports init done.
// Latency: full sweep takes 2^ADDR_WIDTH cycles after reset release or an accepted clear_req.
// Backpressure: clear_req is ignored while a sweep is running; traffic is gated by init_done_o.
module ram_clear_ctrl
   import mmu_ram_pkg::*;
#(
   parameter int ADDR_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear_req_i,
   output logic                  init_done_o,
   output logic                  clr_we_o,
   output logic [ADDR_WIDTH-1:0] clr_addr_o
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

   clr_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;

   // State and sweep address; reset lands in CLEAR so the array is zeroed after every reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_CLEAR;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
      end
   end

   // Next state: sweep stops on the last entry rather than wrapping.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      case (state_q)
         ST_IDLE: begin
            if (clear_req_i) begin
               state_d = ST_CLEAR;
               addr_d  = '0;
            end
         end
         ST_CLEAR: begin
            if (addr_q == LAST_ADDR) begin
               state_d = ST_IDLE;
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_CLEAR;
            addr_d  = '0;
         end
      endcase
   end

   // Outputs decoded from the current state only.
   always_comb begin
      init_done_o = (state_q == ST_IDLE);
      clr_we_o    = (state_q == ST_CLEAR);
      clr_addr_o  = addr_q;
   end

endmodule

// File: rtl/ram_multiport.sv
// Multi-read single-write RAM with byte enables, optional write-first bypass and hardware clear.
// Latency: 1 cycle from read_en to read_data/read_valid; writes visible to reads on the next cycle.
// Backpressure: no handshake; all read/write requests are dropped while init_done is low.
module ram_multiport
   import mmu_ram_pkg::*;
#(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 64,
   parameter int RD_PORTS   = 2,
   parameter int WR_BYPASS  = 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           clear_req,
   output logic                           init_done,
   input  logic                           write_en,
   input  logic [ADDR_WIDTH-1:0]          write_addr,
   input  logic [DATA_WIDTH-1:0]          write_data,
   input  logic [DATA_WIDTH/8-1:0]        write_be,
   input  logic [RD_PORTS-1:0]            read_en,
   input  logic [RD_PORTS*ADDR_WIDTH-1:0] read_addr,
   output logic [RD_PORTS*DATA_WIDTH-1:0] read_data,
   output logic [RD_PORTS-1:0]            read_valid,
   output logic [COLL_CNT_W-1:0]          collision_cnt
);

   localparam int DEPTH  = 2 ** ADDR_WIDTH;
   localparam int NBYTES = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic                  clr_we;
   logic [ADDR_WIDTH-1:0] clr_addr;
   logic                  wr_acc;
   logic [DATA_WIDTH-1:0] wr_merged;
   logic [RD_PORTS-1:0]   hit_vec;
   logic [COLL_CNT_W-1:0] coll_q;

   ram_clear_ctrl #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_clear_ctrl (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear_req_i (clear_req),
      .init_done_o (init_done),
      .clr_we_o    (clr_we),
      .clr_addr_o  (clr_addr)
   );

   assign wr_acc = write_en & init_done;

   // Word as it will look after this cycle's write: old contents with enabled bytes replaced.
   always_comb begin
      wr_merged = mem_q[write_addr];
      for (int k = 0; k < NBYTES; k++) begin
         if (write_be[k]) begin
            wr_merged[8*k +: 8] = write_data[8*k +: 8];
         end
      end
   end

   // Array update; the clear sweep owns the port while init_done is low. Array itself is never reset.
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem_q[clr_addr] <= '0;
      end else if (wr_acc) begin
         mem_q[write_addr] <= wr_merged;
      end
   end

   for (genvar i = 0; i < RD_PORTS; i++) begin : g_rd
      logic [ADDR_WIDTH-1:0] ra;
      logic                  rd_acc;
      logic [DATA_WIDTH-1:0] word;
      logic [DATA_WIDTH-1:0] data_q;
      logic                  valid_q;

      assign ra         = read_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign rd_acc     = read_en[i] & init_done;
      assign hit_vec[i] = rd_acc & wr_acc & (ra == write_addr);
      assign word       = ((WR_BYPASS != 0) && hit_vec[i]) ? wr_merged : mem_q[ra];

      // Registered read; data holds when the port is idle, valid only follows an accepted read.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
         end else begin
            valid_q <= rd_acc;
            if (rd_acc) begin
               data_q <= word;
            end
         end
      end

      assign read_data[i*DATA_WIDTH +: DATA_WIDTH] = data_q;
      assign read_valid[i]                         = valid_q;
   end

   // One count per cycle with any read/write address match, saturating at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         coll_q <= '0;
      end else if (|hit_vec) begin
         coll_q <= coll_sat_inc(coll_q);
      end
   end

   assign collision_cnt = coll_q;

endmodule

// File: tb/tb_ram_multiport.sv
// Directed + randomized bench for ram_multiport, bypass and read-old variants side by side.
// Latency: expectations evaluated 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_ram_multiport;

   localparam int AW    = 6;
   localparam int DW    = 64;
   localparam int RP    = 2;
   localparam int DEPTH = 64;
   localparam int NB    = 8;

   logic           clk        = 1'b0;
   logic           rst_n      = 1'b0;
   logic           clear_req  = 1'b0;
   logic           write_en   = 1'b0;
   logic [AW-1:0]  write_addr = '0;
   logic [DW-1:0]  write_data = '0;
   logic [NB-1:0]  write_be   = '0;
   logic [RP-1:0]  read_en    = '0;
   logic [RP*AW-1:0] read_addr = '0;

   logic             init_done_b, init_done_o;
   logic [RP*DW-1:0] read_data_b, read_data_o;
   logic [RP-1:0]    read_valid_b, read_valid_o;
   logic [15:0]      coll_b, coll_o;

   int errors = 0;
   int checks = 0;

   // Reference model: plain word array, remaining-clear-cycle count, expected registered outputs.
   logic [DW-1:0] mm [DEPTH];
   int            busy;
   logic [DW-1:0] exp_b [RP];
   logic [DW-1:0] exp_o [RP];
   logic [RP-1:0] exp_v;
   int unsigned   exp_cnt;

   always #5 clk = ~clk;

   ram_multiport #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_PORTS(RP), .WR_BYPASS(1)) u_byp (
      .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .init_done(init_done_b),
      .write_en(write_en), .write_addr(write_addr), .write_data(write_data), .write_be(write_be),
      .read_en(read_en), .read_addr(read_addr), .read_data(read_data_b), .read_valid(read_valid_b),
      .collision_cnt(coll_b));

   ram_multiport #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_PORTS(RP), .WR_BYPASS(0)) u_old (
      .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .init_done(init_done_o),
      .write_en(write_en), .write_addr(write_addr), .write_data(write_data), .write_be(write_be),
      .read_en(read_en), .read_addr(read_addr), .read_data(read_data_o), .read_valid(read_valid_o),
      .collision_cnt(coll_o));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      logic [DW-1:0] merged;
      logic [AW-1:0] ra;
      bit            idle;
      bit            hit;
      idle   = (busy == 0);
      hit    = 1'b0;
      merged = mm[write_addr];
      for (int k = 0; k < NB; k++) if (write_be[k]) merged[8*k +: 8] = write_data[8*k +: 8];
      for (int i = 0; i < RP; i++) begin
         if (idle && read_en[i]) begin
            ra = read_addr[i*AW +: AW];
            exp_o[i] = mm[ra];
            if (write_en && ra == write_addr) begin
               hit      = 1'b1;
               exp_b[i] = merged;
            end else begin
               exp_b[i] = mm[ra];
            end
            exp_v[i] = 1'b1;
         end else begin
            exp_v[i] = 1'b0;
         end
      end
      if (hit && exp_cnt < 32'hFFFF) exp_cnt++;
      if (idle) begin
         if (write_en) mm[write_addr] = merged;
         if (clear_req) busy = DEPTH;
      end else begin
         mm[DEPTH-busy] = '0;
         busy--;
      end
   endtask

   task automatic check_all();
      check("init_done_byp", init_done_b, busy == 0);
      check("init_done_old", init_done_o, busy == 0);
      check("coll_byp", coll_b, exp_cnt);
      check("coll_old", coll_o, exp_cnt);
      for (int i = 0; i < RP; i++) begin
         check($sformatf("valid_byp%0d", i), read_valid_b[i], exp_v[i]);
         check($sformatf("valid_old%0d", i), read_valid_o[i], exp_v[i]);
         check($sformatf("data_byp%0d", i), read_data_b[i*DW +: DW], exp_b[i]);
         check($sformatf("data_old%0d", i), read_data_o[i*DW +: DW], exp_o[i]);
      end
   endtask

   task automatic cycle(input bit do_chk);
      model_step();
      @(posedge clk);
      #1;
      if (do_chk) check_all();
      @(negedge clk);
   endtask

   task automatic quiet();
      clear_req = 1'b0; write_en = 1'b0; write_be = '0; read_en = '0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      #1;
      busy    = DEPTH;
      exp_cnt = 0;
      exp_v   = '0;
      for (int i = 0; i < RP; i++) begin
         exp_b[i] = '0;
         exp_o[i] = '0;
      end
      check_all();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic rand_traffic(input int amax);
      write_en   = 1'($urandom);
      write_addr = 6'($urandom_range(0, amax));
      write_data = {$urandom, $urandom};
      write_be   = 8'($urandom);
      read_en    = 2'($urandom);
      read_addr  = {6'($urandom_range(0, amax)), 6'($urandom_range(0, amax))};
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int low;
      for (int a = 0; a < DEPTH; a++) mm[a] = '0;
      busy = DEPTH; exp_cnt = 0; exp_v = '0;
      @(negedge clk);
      apply_reset();

      // Post-reset sweep with traffic that must be ignored.
      for (int c = 0; c < DEPTH; c++) begin
         write_en = 1'b1; write_addr = 6'($urandom); write_data = {$urandom, $urandom};
         write_be = '1; read_en = '1; read_addr = 12'($urandom);
         cycle(1);
      end
      check("init_after_64", init_done_b, 1'b1);
      quiet();

      // Every entry reads back zero.
      for (int j = 0; j < DEPTH/2; j++) begin
         read_en = 2'b11; read_addr = {6'(2*j+1), 6'(2*j)};
         cycle(1);
         check("zero_p0", read_data_b[DW-1:0], 64'd0);
         check("zero_p1", read_data_b[2*DW-1:DW], 64'd0);
      end
      quiet();

      // Byte-enable write.
      write_en = 1'b1; write_addr = 6'd5; write_data = 64'h1122334455667788; write_be = 8'hFF;
      cycle(1);
      write_data = 64'h00000000000000FF; write_be = 8'h01;
      cycle(1);
      quiet(); read_en = 2'b11; read_addr = {6'd5, 6'd5};
      cycle(1);
      check("be_byp", read_data_b[DW-1:0], 64'h11223344556677FF);
      check("be_old", read_data_o[2*DW-1:DW], 64'h11223344556677FF);
      quiet();

      // Same-cycle write/read at address 9.
      write_en = 1'b1; write_addr = 6'd9; write_data = '0; write_be = 8'hFF;
      cycle(1);
      write_data = 64'hAAAA_AAAA_AAAA_AAAA; read_en = 2'b11; read_addr = {6'd9, 6'd9};
      cycle(1);
      check("bypass_p0", read_data_b[DW-1:0], 64'hAAAA_AAAA_AAAA_AAAA);
      check("bypass_p1", read_data_b[2*DW-1:DW], 64'hAAAA_AAAA_AAAA_AAAA);
      check("readold_p0", read_data_o[DW-1:0], 64'd0);
      check("readold_p1", read_data_o[2*DW-1:DW], 64'd0);
      check("coll_one", coll_b, 16'd1);
      quiet();

      // Random traffic on a narrow address window to provoke collisions.
      for (int c = 0; c < 300; c++) begin
         rand_traffic(7);
         cycle(1);
      end
      for (int c = 0; c < 100; c++) begin
         rand_traffic(63);
         cycle(1);
      end

      // Clear request after writes; traffic and a second request during the sweep are ignored.
      rand_traffic(63); write_en = 1'b1; clear_req = 1'b1;
      cycle(1);
      for (int c = 0; c < DEPTH; c++) begin
         rand_traffic(63); clear_req = (c == 10);
         cycle(1);
      end
      check("clear_done", init_done_b, 1'b1);
      quiet();
      for (int j = 0; j < DEPTH/2; j++) begin
         read_en = 2'b11; read_addr = {6'(2*j+1), 6'(2*j)};
         cycle(1);
         check("clr_zero_p0", read_data_o[DW-1:0], 64'd0);
         check("clr_zero_p1", read_data_o[2*DW-1:DW], 64'd0);
      end
      quiet();

      // Reset at clear cycle 30 restarts the full sweep.
      for (int c = 0; c < 8; c++) begin
         write_en = 1'b1; write_addr = 6'(c); write_data = {$urandom, $urandom}; write_be = '1;
         cycle(1);
      end
      quiet(); clear_req = 1'b1;
      cycle(1);
      clear_req = 1'b0;
      for (int c = 0; c < 30; c++) cycle(1);
      apply_reset();
      low = 0;
      while (!init_done_b && low < 200) begin
         cycle(1);
         low++;
      end
      check("restart_len", low, 64);
      read_en = 2'b11; read_addr = {6'd7, 6'd3};
      cycle(1);
      check("restart_zero", read_data_b[DW-1:0], 64'd0);
      quiet();

      // Saturation of the collision counter.
      write_en = 1'b1; write_addr = 6'd1; write_be = '0; read_en = 2'b01; read_addr = 12'd1;
      while (exp_cnt < 32'hFFFF) cycle(0);
      cycle(1);
      check("sat_byp", coll_b, 16'hFFFF);
      check("sat_old", coll_o, 16'hFFFF);
      quiet();
      cycle(1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
